// File: rtl/scale_buf_ctrl_if.sv
// Handshake bundle for scale_buf_ctrl: table-load configuration, 32-bit load
// stream and indexed line-read port. The controller takes the slave side.
interface scale_buf_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 128,
    parameter int unsigned IW = 32
);
    logic          cfg_start;
    logic [AW:0]   cfg_num_lines;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_data;
    logic          rd_req;
    logic          rd_ready;
    logic [AW-1:0] rd_idx;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_oob;

    modport master (
        output cfg_start, cfg_num_lines, wr_valid, wr_data, rd_req, rd_idx,
        input  wr_ready, rd_ready, rd_valid, rd_data, rd_oob
    );

    modport slave (
        input  cfg_start, cfg_num_lines, wr_valid, wr_data, rd_req, rd_idx,
        output wr_ready, rd_ready, rd_valid, rd_data, rd_oob
    );
endinterface

// File: rtl/scale_buf_ctrl.sv
// Scale/bias buffer controller: packs the DMA load stream into SRAM lines and
// serves indexed line reads. Loads and reads time-share the single SRAM port;
// the DRAIN state keeps a read and a write from ever meeting in one cycle.
module scale_buf_ctrl #(
    parameter int unsigned DW      = 128,
    parameter int unsigned AW      = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IW      = 32,
    parameter int unsigned WPL     = 4,
    parameter int unsigned N_DELAY = 1
) (
    input  logic            clk,
    input  logic            rst,
    scale_buf_ctrl_if.slave bus,
    output logic            load_done,
    output logic            table_valid,
    output logic            busy,
    output logic            mem_cs,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);
    localparam int unsigned BW        = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [AW:0] DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WPL - 1);

    typedef enum logic [1:0] {StIdle, StReady, StDrain, StLoad} state_e;

    state_e              state_q;
    logic [AW:0]         num_lines_q;
    logic [AW:0]         line_ptr_q;
    logic [BW-1:0]       beat_q;
    logic [DW-1:0]       pack_q;
    logic                wr_pend_q;
    logic [N_DELAY-1:0]  vld_pipe_q;
    logic [N_DELAY-1:0]  oob_pipe_q;

    logic                wr_fire;
    logic                rd_fire;
    logic                in_flight;
    logic                idx_oob;
    logic                last_line;
    logic [AW:0]         cfg_lines;

    // Handshakes, read-pipe occupancy and the clamped line count for a new table.
    always_comb begin
        bus.wr_ready = (state_q == StLoad);
        bus.rd_ready = (state_q == StReady);
        busy         = (state_q == StDrain) || (state_q == StLoad);
        wr_fire      = bus.wr_valid & bus.wr_ready;
        rd_fire      = bus.rd_req & bus.rd_ready;
        in_flight    = |vld_pipe_q;
        idx_oob      = ({1'b0, bus.rd_idx} >= num_lines_q);
        last_line    = (line_ptr_q == num_lines_q - 1'b1);
        cfg_lines    = bus.cfg_num_lines;
        if (bus.cfg_num_lines == '0 || bus.cfg_num_lines > DEPTH_L) begin
            cfg_lines = DEPTH_L;
        end
        bus.rd_valid = vld_pipe_q[N_DELAY-1];
        bus.rd_oob   = oob_pipe_q[N_DELAY-1];
        bus.rd_data  = mem_rdata;
    end

    // SRAM port: a pending line write, else a newly issued read, else keep the
    // SRAM read pipe advancing (address 0) while earlier reads are still in it.
    always_comb begin
        mem_cs    = wr_pend_q | rd_fire | in_flight;
        mem_we    = wr_pend_q;
        mem_wdata = pack_q;
        mem_addr  = '0;
        if (wr_pend_q) begin
            mem_addr = line_ptr_q[AW-1:0];
        end else if (rd_fire) begin
            mem_addr = bus.rd_idx;
        end
    end

    // Control FSM with line packing, line pointer and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            num_lines_q <= '0;
            line_ptr_q  <= '0;
            beat_q      <= '0;
            pack_q      <= '0;
            wr_pend_q   <= 1'b0;
            load_done   <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            load_done <= 1'b0;
            // Write goes out the cycle after the line's final beat; beats keep flowing.
            wr_pend_q <= wr_fire && (beat_q == LAST_BEAT);
            if (wr_fire) begin
                for (int k = 0; k < int'(WPL); k++) begin
                    if (beat_q == BW'(k)) begin
                        pack_q[k*IW +: IW] <= bus.wr_data;
                    end
                end
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.cfg_start) begin
                        num_lines_q <= cfg_lines;
                        line_ptr_q  <= '0;
                        beat_q      <= '0;
                        state_q     <= StLoad;
                    end
                end
                StReady: begin
                    if (bus.cfg_start) begin
                        table_valid <= 1'b0;
                        num_lines_q <= cfg_lines;
                        line_ptr_q  <= '0;
                        beat_q      <= '0;
                        state_q     <= (in_flight || rd_fire) ? StDrain : StLoad;
                    end
                end
                StDrain: begin
                    if (!in_flight) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (wr_pend_q) begin
                        line_ptr_q <= line_ptr_q + 1'b1;
                        if (last_line) begin
                            load_done   <= 1'b1;
                            table_valid <= 1'b1;
                            state_q     <= StReady;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read pipe: valid and out-of-range flag travel N_DELAY cycles with each read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            oob_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= rd_fire;
            oob_pipe_q[0] <= rd_fire & idx_oob;
            for (int i = 1; i < int'(N_DELAY); i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                oob_pipe_q[i] <= oob_pipe_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_scale_buf_ctrl.sv
// Bench for scale_buf_ctrl: instance A (1-cycle SRAM) and instance C (3-cycle SRAM),
// each with a behavioural SRAM. Expected writes/reads are queued when stimulus is
// driven and compared against what the DUT produces.
`timescale 1ns/1ps
module tb_scale_buf_ctrl;
    localparam int unsigned DW = 128, AW = 4, DEPTH = 16, IW = 32, WPL = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } wr_ev_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          oob;
        logic [31:0]   cyc;
    } rd_ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scale_buf_ctrl_if #(.AW(AW), .DW(DW), .IW(IW)) bus_a ();
    scale_buf_ctrl_if #(.AW(AW), .DW(DW), .IW(IW)) bus_c ();

    logic          a_done, a_tv, a_busy, a_cs, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          c_done, c_tv, c_busy, c_cs, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;

    scale_buf_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .IW(IW), .WPL(WPL), .N_DELAY(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .load_done(a_done), .table_valid(a_tv),
        .busy(a_busy), .mem_cs(a_cs), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata)
    );

    scale_buf_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .IW(IW), .WPL(WPL), .N_DELAY(3)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .load_done(c_done), .table_valid(c_tv),
        .busy(c_busy), .mem_cs(c_cs), .mem_we(c_we), .mem_addr(c_addr),
        .mem_wdata(c_wdata), .mem_rdata(c_rdata)
    );

    // Behavioural SRAMs: A registers read data once, C through a 3-stage pipe.
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_c [DEPTH];
    logic [DW-1:0] c_p0, c_p1;
    always @(posedge clk) begin
        if (a_cs && a_we) mem_a[a_addr] <= a_wdata;
        else if (a_cs) a_rdata <= mem_a[a_addr];
    end
    always @(posedge clk) begin
        if (c_cs && c_we) mem_c[c_addr] <= c_wdata;
        else if (c_cs) begin
            c_p0    <= mem_c[c_addr];
            c_p1    <= c_p0;
            c_rdata <= c_p1;
        end
    end

    // Scoreboard queues and reference table for instance A.
    wr_ev_t        obs_wr[$], exp_wr[$];
    rd_ev_t        obs_rd[$], exp_rd[$], exp_rc[$];
    logic [31:0]   done_cyc[$];
    logic [IW-1:0] stream[$];
    logic [AW-1:0] ridx[$];
    logic [DW-1:0] ref_line [DEPTH];
    int            ref_lines = 0;
    wr_ev_t        mw;
    rd_ev_t        mr;

    // Monitor for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_cs && a_we) begin
                mw.addr = a_addr; mw.data = a_wdata; mw.cyc = cyc;
                obs_wr.push_back(mw);
            end
            if (bus_a.rd_valid) begin
                mr.data = bus_a.rd_data; mr.oob = bus_a.rd_oob; mr.cyc = cyc;
                obs_rd.push_back(mr);
            end
            if (a_done) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.cfg_start = 0; bus_a.cfg_num_lines = '0; bus_a.wr_valid = 0; bus_a.wr_data = '0;
        bus_a.rd_req = 0; bus_a.rd_idx = '0;
        bus_c.cfg_start = 0; bus_c.cfg_num_lines = '0; bus_c.wr_valid = 0; bus_c.wr_data = '0;
        bus_c.rd_req = 0; bus_c.rd_idx = '0;
    endtask

    // Load `stream` into A with cfg_num_lines=num; expect `lines` line writes.
    task automatic load_a(input logic [AW:0] num, input int lines, input bit gapped,
                          input string tag);
        logic [DW-1:0] line;
        wr_ev_t        ex, ob;
        bit            got;
        logic [31:0]   last_wr, dc;
        obs_wr.delete(); exp_wr.delete(); done_cyc.delete();
        bus_a.cfg_num_lines = num; bus_a.cfg_start = 1;
        step();
        bus_a.cfg_start = 0;
        for (int l = 0; l < lines; l++) begin
            line = '0;
            for (int k = 0; k < int'(WPL); k++) line[k*IW +: IW] = stream[l*WPL + k];
            ex.addr = AW'(l); ex.data = line; ex.cyc = '0;
            exp_wr.push_back(ex);
            ref_line[l] = line;
        end
        ref_lines = lines;
        for (int b = 0; b < stream.size(); b++) begin
            if (gapped) repeat ($urandom_range(0, 2)) step();
            bus_a.wr_valid = 1; bus_a.wr_data = stream[b];
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                got = bus_a.wr_ready;
                step();
            end
            bus_a.wr_valid = 0;
            if (!got) begin
                n_cmp++; n_err++;
                $display("FAIL %s beat %0d: wr_ready never seen", tag, b);
            end
        end
        for (int c = 0; c < 100 && (obs_wr.size() < lines || done_cyc.size() < 1); c++) step();
        n_cmp++;
        if (obs_wr.size() !== lines || done_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL %s count: writes %0d done %0d, want %0d / 1", tag, obs_wr.size(),
                     done_cyc.size(), lines);
        end
        last_wr = '0;
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            ob = obs_wr.pop_front(); ex = exp_wr.pop_front();
            last_wr = ob.cyc;
            n_cmp++;
            if (ob.addr !== ex.addr || ob.data !== ex.data) begin
                n_err++;
                $display("FAIL %s write: got @%0d %h want @%0d %h", tag, ob.addr, ob.data,
                         ex.addr, ex.data);
            end
        end
        if (done_cyc.size() > 0) begin
            dc = done_cyc.pop_front();
            n_cmp++;
            if (dc !== last_wr + 1) begin
                n_err++;
                $display("FAIL %s load_done cycle: got %0d want %0d", tag, dc, last_wr + 1);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({a_tv, bus_a.rd_ready, a_busy} !== 3'b110) begin
            n_err++;
            $display("FAIL %s ready state: tv/rd_ready/busy got %b want 110", tag,
                     {a_tv, bus_a.rd_ready, a_busy});
        end
        step();
    endtask

    // Issue reads of `ridx` to A on consecutive cycles and compare results.
    task automatic read_a(input string tag);
        rd_ev_t ex, ob;
        int     n;
        obs_rd.delete(); exp_rd.delete();
        n = ridx.size();
        foreach (ridx[i]) begin
            bus_a.rd_req = 1; bus_a.rd_idx = ridx[i];
            n_cmp++;
            if (bus_a.rd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s rd_ready: got %b want 1", tag, bus_a.rd_ready);
            end
            ex.oob  = (int'(ridx[i]) >= ref_lines);
            ex.data = ref_line[ridx[i]];
            ex.cyc  = cyc + 1;
            exp_rd.push_back(ex);
            step();
        end
        bus_a.rd_req = 0;
        for (int c = 0; c < 20 && obs_rd.size() < n; c++) step();
        n_cmp++;
        if (obs_rd.size() !== n) begin
            n_err++;
            $display("FAIL %s read count: got %0d want %0d", tag, obs_rd.size(), n);
        end
        while (obs_rd.size() > 0 && exp_rd.size() > 0) begin
            ob = obs_rd.pop_front(); ex = exp_rd.pop_front();
            n_cmp++;
            if (ob.oob !== ex.oob || ob.cyc !== ex.cyc || (!ex.oob && ob.data !== ex.data)) begin
                n_err++;
                $display("FAIL %s read: got oob %b cyc %0d %h want oob %b cyc %0d %h", tag,
                         ob.oob, ob.cyc, ob.data, ex.oob, ex.cyc, ex.data);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) step();
        @(negedge clk);
        n_cmp++;
        if ({bus_a.wr_ready, bus_a.rd_ready, bus_a.rd_valid, bus_a.rd_oob, a_done, a_tv, a_busy,
             a_cs, a_we} !== 9'b0) begin
            n_err++;
            $display("FAIL reset flags: got %b want 0", {bus_a.wr_ready, bus_a.rd_ready,
                     bus_a.rd_valid, bus_a.rd_oob, a_done, a_tv, a_busy, a_cs, a_we});
        end
        n_cmp++;
        if (a_addr !== '0 || a_wdata !== '0) begin
            n_err++;
            $display("FAIL reset mem bus: got %h %h want 0", a_addr, a_wdata);
        end
        rst = 0;
        step();
    endtask

    task automatic test_idle_read();
        obs_rd.delete();
        bus_a.rd_req = 1; bus_a.rd_idx = 4'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_a.rd_ready !== 1'b0 || a_cs !== 1'b0) begin
                n_err++;
                $display("FAIL idle read: rd_ready %b mem_cs %b want 0 0", bus_a.rd_ready, a_cs);
            end
            step();
        end
        bus_a.rd_req = 0;
        repeat (3) step();
        n_cmp++;
        if (obs_rd.size() !== 0) begin
            n_err++;
            $display("FAIL idle read rd_valid: got %0d want 0", obs_rd.size());
        end
    endtask

    task automatic test_load_two();
        stream.delete();
        for (int i = 0; i < 8; i++) stream.push_back(IW'(i));
        load_a(5'd2, 2, 1'b0, "load2");
    endtask

    task automatic test_back_to_back_reads();
        ridx.delete();
        ridx.push_back(4'd1); ridx.push_back(4'd0); ridx.push_back(4'd1);
        read_a("b2b_read");
    endtask

    task automatic test_oob();
        ridx.delete();
        ridx.push_back(4'd5); ridx.push_back(4'd2); ridx.push_back(4'd1);
        read_a("oob_read");
    endtask

    // Feed one line into instance C and wait for its load_done.
    task automatic feed_c(input logic [IW-1:0] base, output logic [DW-1:0] line);
        bit got;
        line = '0;
        for (int k = 0; k < int'(WPL); k++) begin
            bus_c.wr_valid = 1; bus_c.wr_data = base + IW'(k);
            line[k*IW +: IW] = base + IW'(k);
            step();
        end
        bus_c.wr_valid = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = c_done;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL drain load_done: got 0 want 1");
        end
        step();
    endtask

    task automatic test_drain();
        logic [DW-1:0] line;
        rd_ev_t        ex;
        int            drain, we_seen, vcnt;
        bit            loaded;
        exp_rc.delete();
        bus_c.cfg_num_lines = 5'd1; bus_c.cfg_start = 1;
        step();
        bus_c.cfg_start = 0;
        feed_c(32'hA0, line);
        for (int i = 0; i < 2; i++) begin
            bus_c.rd_req = 1; bus_c.rd_idx = '0;
            n_cmp++;
            if (bus_c.rd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL drain rd_ready: got %b want 1", bus_c.rd_ready);
            end
            ex.data = line; ex.oob = 0; ex.cyc = cyc + 3;
            exp_rc.push_back(ex);
            step();
        end
        bus_c.rd_req = 0; bus_c.cfg_num_lines = 5'd1; bus_c.cfg_start = 1;
        step();
        bus_c.cfg_start = 0;
        drain = 0; we_seen = 0; vcnt = 0; loaded = 0;
        for (int c = 0; c < 30 && !loaded; c++) begin
            @(negedge clk);
            if (c_busy && !bus_c.wr_ready) drain++;
            if (c_we) we_seen++;
            if (bus_c.rd_valid) begin
                vcnt++;
                if (exp_rc.size() > 0) begin
                    ex = exp_rc.pop_front();
                    n_cmp++;
                    if (bus_c.rd_data !== ex.data || bus_c.rd_oob !== 1'b0 || cyc !== ex.cyc) begin
                        n_err++;
                        $display("FAIL drain read: got %h oob %b cyc %0d want %h oob 0 cyc %0d",
                                 bus_c.rd_data, bus_c.rd_oob, cyc, ex.data, ex.cyc);
                    end
                end
            end
            if (bus_c.wr_ready) loaded = 1;
        end
        n_cmp++;
        if (drain < 2 || we_seen !== 0 || vcnt !== 2 || !loaded || c_tv !== 1'b0) begin
            n_err++;
            $display("FAIL drain: drain %0d we %0d valids %0d loaded %0d tv %b want >=2 0 2 1 0",
                     drain, we_seen, vcnt, loaded, c_tv);
        end
        step();
        feed_c(32'hB0, line);
        // Reset with a read still in the 3-deep pipe: its rd_valid must never appear.
        bus_c.rd_req = 1; bus_c.rd_idx = '0;
        step();
        bus_c.rd_req = 0;
        rst = 1;
        step();
        rst = 0;
        vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_c.rd_valid) vcnt++;
        end
        n_cmp++;
        if (vcnt !== 0 || c_tv !== 1'b0) begin
            n_err++;
            $display("FAIL dropped read: valids %0d tv %b want 0 0", vcnt, c_tv);
        end
        ref_lines = 0;
        step();
    endtask

    task automatic test_full_table();
        stream.delete();
        for (int i = 0; i < int'(DEPTH * WPL); i++) stream.push_back($urandom);
        load_a(5'd0, 16, 1'b1, "full_gapped");
        load_a(5'd20, 16, 1'b0, "full_b2b");
        ridx.delete();
        ridx.push_back(4'd15); ridx.push_back(4'd0); ridx.push_back(4'd9);
        read_a("full_read");
    endtask

    task automatic test_reset_mid_load();
        wr_ev_t ob;
        obs_wr.delete();
        bus_a.cfg_num_lines = 5'd2; bus_a.cfg_start = 1;
        step();
        bus_a.cfg_start = 0;
        for (int b = 0; b < 6; b++) begin
            bus_a.wr_valid = 1; bus_a.wr_data = 32'hC0 + IW'(b);
            step();
        end
        bus_a.wr_valid = 0;
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if ({bus_a.wr_ready, bus_a.rd_ready, bus_a.rd_valid, a_done, a_tv, a_busy, a_cs, a_we}
            !== 8'b0 || a_wdata !== '0) begin
            n_err++;
            $display("FAIL mid-load reset: flags %b wdata %h want 0", {bus_a.wr_ready,
                     bus_a.rd_ready, bus_a.rd_valid, a_done, a_tv, a_busy, a_cs, a_we}, a_wdata);
        end
        n_cmp++;
        if (obs_wr.size() !== 1) begin
            n_err++;
            $display("FAIL mid-load writes: got %0d want 1", obs_wr.size());
        end else begin
            ob = obs_wr.pop_front();
            n_cmp++;
            if (ob.addr !== '0 || ob.data !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) begin
                n_err++;
                $display("FAIL mid-load line0: got @%0d %h", ob.addr, ob.data);
            end
        end
        step();
        rst = 0;
        step();
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(32'hD0 + IW'(i));
        load_a(5'd1, 1, 1'b0, "reload1");
        repeat (10) step();
        n_cmp++;
        if (obs_wr.size() !== 0) begin
            n_err++;
            $display("FAIL reload extra writes: got %0d want 0", obs_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_load_two();
        test_back_to_back_reads();
        test_oob();
        test_drain();
        test_full_table();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
